// File: rtl/aer_spike_encoder_pkg.sv
// Shared definitions for the AER spike encoder: FSM encoding, tick address
// and the LFSR feedback polynomial.
package aer_spike_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EVAL    = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_REQ_LO  = 3'd4,
        ST_TICK_HI = 3'd5,
        ST_TICK_LO = 3'd6,
        ST_FINISH  = 3'd7
    } state_e;

    localparam logic [11:0] TICK_ADDR     = 12'hFFF;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
    endfunction

endpackage

// File: rtl/aer_spike_encoder_if.sv
// Pixel-load, control and 4-phase AER bus of the spike encoder.
// master = encoder side, slave = host / SNN core side.
interface aer_spike_encoder_if #(
    parameter int AER_WIDTH   = 12,
    parameter int PIXEL_WIDTH = 8
);
    logic                   PIX_WE;
    logic [9:0]             PIX_ADDR;
    logic [PIXEL_WIDTH-1:0] PIX_DATA;
    logic                   START;
    logic                   MODE;
    logic [AER_WIDTH-1:0]   AERIN_ADDR;
    logic                   AERIN_REQ;
    logic                   AERIN_ACK;
    logic                   BUSY;
    logic                   DONE;

    modport master (
        input  PIX_WE, PIX_ADDR, PIX_DATA, START, MODE, AERIN_ACK,
        output AERIN_ADDR, AERIN_REQ, BUSY, DONE
    );

    modport slave (
        output PIX_WE, PIX_ADDR, PIX_DATA, START, MODE, AERIN_ACK,
        input  AERIN_ADDR, AERIN_REQ, BUSY, DONE
    );
endinterface

// File: rtl/aer_spike_encoder_pixel_buf_sp.sv
// Single-port synchronous pixel RAM, one-cycle read latency, no reset so it
// maps onto block memory.
module pixel_buf_sp
    import aer_spike_encoder_pkg::*;
#(
    parameter int DEPTH  = 784,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port and registered read (old data on a same-address write)
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        rdata_r <= mem_r[addr];
    end

    assign rdata = rdata_r;
endmodule

// File: rtl/aer_spike_encoder.sv
// Converts a buffered pixel sample into a stream of AER spike events over
// TIME_STEP steps, each step closed by a tick event at address 12'hFFF.
module aer_spike_encoder
    import aer_spike_encoder_pkg::*;
#(
    parameter int          INPUT_NEURON = 784,
    parameter int          TIME_STEP    = 8,
    parameter int          AER_WIDTH    = 12,
    parameter int          PIXEL_WIDTH  = 8,
    parameter int          THRESH       = 128,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic                 CLK,
    input logic                 RST_N,
    aer_spike_encoder_if.master bus
);
    localparam int N_W = 10;
    localparam int T_W = $clog2(TIME_STEP + 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(INPUT_NEURON - 1);
    localparam logic [N_W-1:0] N_CNT  = N_W'(INPUT_NEURON);
    localparam logic [T_W-1:0] T_LAST = T_W'(TIME_STEP - 1);

    state_e                 state_r, state_s;
    logic [N_W-1:0]         n_r, n_s;
    logic [T_W-1:0]         t_r, t_s;
    logic [15:0]            lfsr_r, lfsr_s;
    logic                   mode_r, mode_s;
    logic                   req_r, busy_r, done_r;
    logic [AER_WIDTH-1:0]   addr_r;
    logic [PIXEL_WIDTH-1:0] pix_s;
    logic                   spike_s;
    logic                   ram_we_s;
    logic [N_W-1:0]         ram_addr_s;

    // The RAM port is owned by the host while idle and by the scanner while busy
    assign ram_we_s   = bus.PIX_WE & ~busy_r & (bus.PIX_ADDR < N_CNT);
    assign ram_addr_s = busy_r ? n_r : bus.PIX_ADDR;

    pixel_buf_sp #(
        .DEPTH  (INPUT_NEURON),
        .WIDTH  (PIXEL_WIDTH),
        .ADDR_W (N_W)
    ) u_pixel_buf (
        .CLK   (CLK),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (bus.PIX_DATA),
        .rdata (pix_s)
    );

    assign spike_s = mode_r ? (pix_s >= PIXEL_WIDTH'(THRESH))
                            : (pix_s >  PIXEL_WIDTH'(lfsr_r[7:0]));

    // Next-state, counter and LFSR update logic
    always_comb begin
        state_s = state_r;
        n_s     = n_r;
        t_s     = t_r;
        lfsr_s  = lfsr_r;
        mode_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.START) begin
                    mode_s  = bus.MODE;
                    n_s     = '0;
                    t_s     = '0;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_EVAL;
            end
            ST_EVAL: begin
                lfsr_s = lfsr_next(lfsr_r);
                if (spike_s) begin
                    state_s = ST_REQ_HI;
                end else if (n_r == N_LAST) begin
                    state_s = ST_TICK_HI;
                end else begin
                    n_s     = n_r + 10'd1;
                    state_s = ST_FETCH;
                end
            end
            ST_REQ_HI: begin
                if (bus.AERIN_ACK) begin
                    state_s = ST_REQ_LO;
                end else begin
                    state_s = ST_REQ_HI;
                end
            end
            ST_REQ_LO: begin
                if (bus.AERIN_ACK) begin
                    state_s = ST_REQ_LO;
                end else if (n_r == N_LAST) begin
                    state_s = ST_TICK_HI;
                end else begin
                    n_s     = n_r + 10'd1;
                    state_s = ST_FETCH;
                end
            end
            ST_TICK_HI: begin
                if (bus.AERIN_ACK) begin
                    state_s = ST_TICK_LO;
                end else begin
                    state_s = ST_TICK_HI;
                end
            end
            ST_TICK_LO: begin
                if (bus.AERIN_ACK) begin
                    state_s = ST_TICK_LO;
                end else if (t_r < T_LAST) begin
                    t_s     = t_r + T_W'(1);
                    n_s     = '0;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state they belong to
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            n_r     <= '0;
            t_r     <= '0;
            lfsr_r  <= LFSR_SEED;
            mode_r  <= 1'b0;
            req_r   <= 1'b0;
            addr_r  <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            n_r     <= n_s;
            t_r     <= t_s;
            lfsr_r  <= lfsr_s;
            mode_r  <= mode_s;
            req_r   <= (state_s == ST_REQ_HI) || (state_s == ST_TICK_HI);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_FINISH);
            if (state_s == ST_REQ_HI) begin
                addr_r <= AER_WIDTH'(n_r);
            end else if (state_s == ST_TICK_HI) begin
                addr_r <= AER_WIDTH'(TICK_ADDR);
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    assign bus.AERIN_REQ  = req_r;
    assign bus.AERIN_ADDR = addr_r;
    assign bus.BUSY       = busy_r;
    assign bus.DONE       = done_r;
endmodule

// File: tb/tb_aer_spike_encoder.sv
// Scoreboard bench for aer_spike_encoder: a reference model fills an expected
// event queue, a monitor pops and compares on every REQ rise and DONE pulse.
module tb_aer_spike_encoder;
    localparam int          NPIX      = 784;
    localparam int          TS        = 8;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam int          TICK      = 4095;
    localparam int          DONE_MARK = -1;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    initial forever #5 CLK = ~CLK;

    aer_spike_encoder_if #(.AER_WIDTH(12), .PIXEL_WIDTH(8)) bus ();

    aer_spike_encoder #(
        .INPUT_NEURON (NPIX),
        .TIME_STEP    (TS),
        .AER_WIDTH    (12),
        .PIXEL_WIDTH  (8),
        .THRESH       (128),
        .LFSR_SEED    (SEED)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_q[$];
    int          ev_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  ref_pix [NPIX];
    logic [15:0] ref_lfsr = SEED;
    int          ref_spikes = 0;
    int          ack_mode = 1;
    logic        ack_force = 1'b0;
    int          ack_dly = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // One shift of the 16-bit Fibonacci register with taps 16,14,13,11
    function automatic logic [15:0] ref_step(input logic [15:0] s);
        int   taps[4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= s[taps[i]-1];
        return {s[14:0], fb};
    endfunction

    task automatic build_expected(input logic mode);
        logic spike;
        ref_spikes = 0;
        for (int t = 0; t < TS; t++) begin
            for (int n = 0; n < NPIX; n++) begin
                spike = mode ? (ref_pix[n] >= 8'd128) : (ref_pix[n] > ref_lfsr[7:0]);
                ref_lfsr = ref_step(ref_lfsr);
                if (spike) begin
                    exp_q.push_back(n);
                    ref_spikes++;
                end
            end
            exp_q.push_back(TICK);
        end
        exp_q.push_back(DONE_MARK);
    endtask

    task automatic write_pix(input int a, input logic [7:0] d);
        bus.PIX_WE   = 1'b1;
        bus.PIX_ADDR = 10'(a);
        bus.PIX_DATA = d;
        @(posedge CLK); #1;
        bus.PIX_WE   = 1'b0;
    endtask

    task automatic write_all();
        for (int a = 0; a < NPIX; a++) write_pix(a, ref_pix[a]);
    endtask

    task automatic pulse_start(input logic mode);
        bus.MODE  = mode;
        bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
    endtask

    task automatic run_sample(input logic mode, input bit poke_busy, input bit check_busy);
        int cyc;
        int busy_low;
        int d0;
        build_expected(mode);
        d0 = done_cnt;
        busy_low = 0;
        cyc = 0;
        pulse_start(mode);
        while (done_cnt == d0 && cyc < 60000) begin
            if (poke_busy && cyc == 20) begin
                bus.PIX_WE   = 1'b1;
                bus.PIX_ADDR = 10'd0;
                bus.PIX_DATA = 8'd255;
            end else begin
                bus.PIX_WE = 1'b0;
            end
            @(negedge CLK);
            if (done_cnt == d0 && !bus.BUSY) busy_low++;
            @(posedge CLK); #1;
            cyc++;
        end
        bus.PIX_WE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        if (check_busy) check("busy_start_to_done", busy_low, 0);
    endtask

    // Core-side acknowledge responder
    initial begin
        int wc;
        wc = 0;
        bus.AERIN_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (ack_mode == 1) begin
                bus.AERIN_ACK = ack_force;
                wc = 0;
            end else if (bus.AERIN_REQ && !bus.AERIN_ACK) begin
                if (wc >= ack_dly) begin
                    bus.AERIN_ACK = 1'b1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else if (!bus.AERIN_REQ && bus.AERIN_ACK) begin
                bus.AERIN_ACK = 1'b0;
            end
        end
    end

    // Monitor: compare every new event and every DONE against the queue
    initial begin
        logic       prev_req;
        logic [11:0] held;
        prev_req = 1'b0;
        held = 12'd0;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                prev_req = 1'b0;
            end else begin
                if (bus.AERIN_REQ && !prev_req) begin
                    ev_cnt++;
                    held = bus.AERIN_ADDR;
                    if (exp_q.size() == 0) check("unexpected_event", int'(bus.AERIN_ADDR), -2);
                    else check("event_addr", int'(bus.AERIN_ADDR), exp_q.pop_front());
                end else if (bus.AERIN_REQ) begin
                    check("addr_stable", int'(bus.AERIN_ADDR), int'(held));
                end
                if (bus.DONE) begin
                    done_cnt++;
                    if (exp_q.size() == 0) check("unexpected_done", 1, 0);
                    else check("done_position", DONE_MARK, exp_q.pop_front());
                end
                prev_req = bus.AERIN_REQ;
            end
        end
    end

    initial begin
        int e0;
        int cyc;
        int req_hi;
        bus.PIX_WE = 1'b0;
        bus.PIX_ADDR = 10'd0;
        bus.PIX_DATA = 8'd0;
        bus.START = 1'b0;
        bus.MODE = 1'b0;

        // Reset state
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_req", int'(bus.AERIN_REQ), 0);
        check("rst_addr", int'(bus.AERIN_ADDR), 0);
        check("rst_busy", int'(bus.BUSY), 0);
        check("rst_done", int'(bus.DONE), 0);
        RST_N = 1'b1;
        ref_lfsr = SEED;

        // Threshold mode, sparse sample; 127 sits just below threshold
        for (int i = 0; i < NPIX; i++) ref_pix[i] = 8'd0;
        ref_pix[0] = 8'd200; ref_pix[5] = 8'd200; ref_pix[783] = 8'd200; ref_pix[10] = 8'd127;
        write_all();
        ack_mode = 0; ack_dly = 0;
        e0 = ev_cnt;
        run_sample(1'b1, 1'b0, 1'b1);
        check("sparse_event_count", ev_cnt - e0, 32);

        // Bernoulli mode, all-zero sample, with an ignored write while busy
        for (int i = 0; i < NPIX; i++) ref_pix[i] = 8'd0;
        write_all();
        ack_dly = 1;
        e0 = ev_cnt;
        run_sample(1'b0, 1'b1, 1'b1);
        check("zero_sample_ticks_only", ev_cnt - e0, TS);

        // Write after DONE, then latency and stalled acknowledge
        write_pix(0, 8'd128);
        ref_pix[0] = 8'd128;
        ack_mode = 1; ack_force = 1'b0;
        build_expected(1'b1);
        e0 = ev_cnt;
        bus.MODE = 1'b1;
        bus.START = 1'b1;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        check("lat_edge1_req", int'(bus.AERIN_REQ), 0);
        @(posedge CLK); #1;
        check("lat_edge2_req", int'(bus.AERIN_REQ), 0);
        @(posedge CLK); #1;
        check("lat_edge3_req", int'(bus.AERIN_REQ), 1);
        check("lat_edge3_addr", int'(bus.AERIN_ADDR), 0);
        ack_force = 1'b1;
        @(posedge CLK); #1;
        check("req_drop_after_ack", int'(bus.AERIN_REQ), 0);
        req_hi = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (bus.AERIN_REQ) req_hi++;
        end
        check("stall_no_req", req_hi, 0);
        check("stall_one_event", ev_cnt - e0, 1);
        check("stall_busy", int'(bus.BUSY), 1);
        ack_force = 1'b0;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        exp_q.delete();
        ref_lfsr = SEED;

        // Reset during REQ_HI of the fifth event, then rerun from the seed
        for (int i = 0; i < NPIX; i++) ref_pix[i] = 8'($urandom_range(0, 20));
        write_all();
        ack_mode = 0; ack_dly = 2;
        build_expected(1'b0);
        e0 = ev_cnt;
        cyc = 0;
        pulse_start(1'b0);
        while (ev_cnt - e0 < 5 && cyc < 20000) begin
            @(posedge CLK); #1;
            cyc++;
        end
        check("reached_event5", ev_cnt - e0, 5);
        ack_mode = 1; ack_force = 1'b0;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        check("midrst_req", int'(bus.AERIN_REQ), 0);
        check("midrst_addr", int'(bus.AERIN_ADDR), 0);
        check("midrst_busy", int'(bus.BUSY), 0);
        RST_N = 1'b1;
        exp_q.delete();
        ref_lfsr = SEED;
        @(posedge CLK); #1;
        ack_mode = 0;
        run_sample(1'b0, 1'b0, 1'b0);

        // Bernoulli mode, saturated sample
        for (int i = 0; i < NPIX; i++) ref_pix[i] = 8'd255;
        write_all();
        ack_dly = 0;
        e0 = ev_cnt;
        run_sample(1'b0, 1'b0, 1'b0);
        check("saturated_event_count", ev_cnt - e0, ref_spikes + TS);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
